// File: rtl/calc_mode_controller_if.sv
// Command bus of the calculator mode controller: raw buttons and IR frames in,
// datapath op select, enable and pulse outputs back.
`timescale 1ns/1ps

interface calc_mode_controller_if;
   logic        btn_pwr_n;
   logic        btn_add_n;
   logic        btn_sub_n;
   logic        btn_mul_n;
   logic        ir_valid;
   logic [31:0] ir_data;
   logic [1:0]  op_sel;
   logic        en;
   logic        clr;
   logic        mode_chg;

   // Stimulus side: drives buttons and IR, observes controller outputs
   modport master (
      output btn_pwr_n, btn_add_n, btn_sub_n, btn_mul_n, ir_valid, ir_data,
      input  op_sel, en, clr, mode_chg
   );

   // Controller side
   modport slave (
      input  btn_pwr_n, btn_add_n, btn_sub_n, btn_mul_n, ir_valid, ir_data,
      output op_sel, en, clr, mode_chg
   );
endinterface

// File: rtl/calc_mode_controller.sv
// Command front-end and mode sequencer for the 7-bit calculator datapath.
// Debounces four active-low buttons (event on release), optionally decodes IR
// remote frames, arbitrates same-cycle commands and runs OFF/IDLE/ADD/SUB/MUL.
// Optional feature: define IR_CMD_EN to build the IR frame decoder; without it
// ir_valid/ir_data are ignored and only the buttons issue commands.
`timescale 1ns/1ps

module calc_mode_controller #(
   parameter int          DEB_CNT  = 50000,
   parameter int          CNT_W    = 16,
   parameter logic [31:0] CODE_ADD = 32'hF00F6B86,
   parameter logic [31:0] CODE_SUB = 32'hEC136B86,
   parameter logic [31:0] CODE_MUL = 32'hEF106B86,
   parameter logic [31:0] CODE_PWR = 32'hED126B86
) (
   input  logic                  clk,
   input  logic                  rst_n,
   calc_mode_controller_if.slave bus
);

   // Button bit order used throughout: 0 pwr, 1 add, 2 sub, 3 mul
   localparam int NB = 4;
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);

   typedef enum logic [2:0] {
      ST_OFF,
      ST_IDLE,
      ST_ADD,
      ST_SUB,
      ST_MUL
   } state_e;

   logic [NB-1:0]    btn_raw;
   logic [NB-1:0]    sync1_q, sync1_d;
   logic [NB-1:0]    sync2_q, sync2_d;
   logic [NB-1:0]    deb_q,   deb_d;
   logic [NB-1:0]    rel_q,   rel_d;
   logic [CNT_W-1:0] cnt_q [NB];
   logic [CNT_W-1:0] cnt_d [NB];

   state_e           state_q, state_d;
   logic [1:0]       op_sel_q, op_sel_d;
   logic             en_q, en_d;
   logic             clr_q, clr_d;
   logic             mode_chg_q, mode_chg_d;

   logic             ir_pwr, ir_add, ir_sub, ir_mul;

   assign btn_raw = {bus.btn_mul_n, bus.btn_sub_n, bus.btn_add_n, bus.btn_pwr_n};

`ifdef IR_CMD_EN
   // A frame counts only when strobed and equal to one of the four key codes
   assign ir_pwr = bus.ir_valid && (bus.ir_data == CODE_PWR);
   assign ir_add = bus.ir_valid && (bus.ir_data == CODE_ADD);
   assign ir_sub = bus.ir_valid && (bus.ir_data == CODE_SUB);
   assign ir_mul = bus.ir_valid && (bus.ir_data == CODE_MUL);
`else
   logic unused_ir;
   assign unused_ir = ^{bus.ir_valid, bus.ir_data};
   assign ir_pwr = 1'b0;
   assign ir_add = 1'b0;
   assign ir_sub = 1'b0;
   assign ir_mul = 1'b0;
`endif

   // Synchronize, debounce and turn each debounced release into a one-cycle pulse
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves a latch.
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      deb_d   = deb_q;
      rel_d   = '0;
      for (int i = 0; i < NB; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == DEB_LAST) begin
               deb_d[i] = sync2_q[i];
               rel_d[i] = sync2_q[i];  // 0->1 on the debounced level is a release
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Button front-end registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
         deb_q   <= '1;
         rel_q   <= '0;
         // NOTE: the counters are plain flops, so all of them are reset; a reset mid-debounce discards it.
         for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q   <= deb_d;
         rel_q   <= rel_d;
         for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Arbitrate same-cycle commands, pick next state, decode Moore outputs from it
   always_comb begin
      logic   pwr_ev;
      logic   op_ev;
      state_e op_tgt;

      state_d = state_q;
      op_ev   = 1'b0;
      op_tgt  = state_q;
      pwr_ev  = ir_pwr | rel_q[0];

      if (ir_add) begin
         op_ev = 1'b1; op_tgt = ST_ADD;
      end else if (ir_sub) begin
         op_ev = 1'b1; op_tgt = ST_SUB;
      end else if (ir_mul) begin
         op_ev = 1'b1; op_tgt = ST_MUL;
      end else if (rel_q[1]) begin
         op_ev = 1'b1; op_tgt = ST_ADD;
      end else if (rel_q[2]) begin
         op_ev = 1'b1; op_tgt = ST_SUB;
      end else if (rel_q[3]) begin
         op_ev = 1'b1; op_tgt = ST_MUL;
      end

      if (pwr_ev) begin
         state_d = (state_q == ST_OFF) ? ST_IDLE : ST_OFF;
      end else if (op_ev && (state_q != ST_OFF)) begin
         state_d = op_tgt;  // ops while OFF are dropped, not remembered
      end

      unique case (state_d)
         ST_ADD:  op_sel_d = 2'b01;
         ST_SUB:  op_sel_d = 2'b10;
         ST_MUL:  op_sel_d = 2'b11;
         default: op_sel_d = 2'b00;
      endcase
      en_d       = (state_d != ST_OFF);
      clr_d      = (state_q == ST_OFF) && (state_d == ST_IDLE);
      mode_chg_d = (state_d != state_q);
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_OFF;
         op_sel_q   <= 2'b00;
         en_q       <= 1'b0;
         clr_q      <= 1'b0;
         mode_chg_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_sel_q   <= op_sel_d;
         en_q       <= en_d;
         clr_q      <= clr_d;
         mode_chg_q <= mode_chg_d;
      end
   end

   assign bus.op_sel   = op_sel_q;
   assign bus.en       = en_q;
   assign bus.clr      = clr_q;
   assign bus.mode_chg = mode_chg_q;

endmodule

// File: tb/tb_calc_mode_controller.sv
// Directed bench for calc_mode_controller with DEB_CNT=4 (release -> outputs in 7 clk).
// Outputs are compared as {op_sel, en, clr, mode_chg}. IR scenarios build only with IR_CMD_EN.
`timescale 1ns/1ps

module tb_calc_mode_controller;

   localparam int DEB = 4;

   localparam logic [4:0] O_OFF   = 5'b00_0_0_0;
   localparam logic [4:0] O_OFF1  = 5'b00_0_0_1;
   localparam logic [4:0] O_IDLE  = 5'b00_1_0_0;
   localparam logic [4:0] O_IDLE1 = 5'b00_1_1_1;
   localparam logic [4:0] O_ADD   = 5'b01_1_0_0;
   localparam logic [4:0] O_ADD1  = 5'b01_1_0_1;
   localparam logic [4:0] O_SUB   = 5'b10_1_0_0;
   localparam logic [4:0] O_SUB1  = 5'b10_1_0_1;
   localparam logic [4:0] O_MUL   = 5'b11_1_0_0;
   localparam logic [4:0] O_MUL1  = 5'b11_1_0_1;

   // Button masks: bit set = pressed
   localparam logic [3:0] B_PWR = 4'b0001;
   localparam logic [3:0] B_ADD = 4'b0010;
   localparam logic [3:0] B_SUB = 4'b0100;
   localparam logic [3:0] B_MUL = 4'b1000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   calc_mode_controller_if bus ();

   calc_mode_controller #(
      .DEB_CNT (DEB),
      .CNT_W   (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [4:0] obs();
      return {bus.op_sel, bus.en, bus.clr, bus.mode_chg};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btns(input logic [3:0] pressed);
      {bus.btn_mul_n, bus.btn_sub_n, bus.btn_add_n, bus.btn_pwr_n} = ~pressed;
   endtask

   // Press for 'hold' cycles, release; returns on the negedge the release is driven
   task automatic press(input logic [3:0] m, input int hold);
      set_btns(m);
      tick(hold);
      set_btns(4'b0000);
   endtask

   task automatic send_ir(input logic [31:0] code);
      bus.ir_valid = 1'b1;
      bus.ir_data  = code;
      tick(1);
      bus.ir_valid = 1'b0;
      bus.ir_data  = '0;
   endtask

   task automatic test_reset();
      logic [4:0] o;
      tick(2);
      o = obs(); n_vec++;
      if (o !== O_OFF) begin n_err++; $display("FAIL reset_held: got %b want %b", o, O_OFF); end
      rst_n = 1'b1;
      tick(3);
      o = obs(); n_vec++;
      if (o !== O_OFF) begin n_err++; $display("FAIL reset_after: got %b want %b", o, O_OFF); end
   endtask

   task automatic test_power_on();
      logic [4:0] o;
      press(B_PWR, 10);
      tick(6);
      o = obs(); n_vec++;
      if (o !== O_OFF) begin n_err++; $display("FAIL pwr_early: got %b want %b", o, O_OFF); end
      tick(1);
      o = obs(); n_vec++;
      if (o !== O_IDLE1) begin n_err++; $display("FAIL pwr_first: got %b want %b", o, O_IDLE1); end
      tick(1);
      o = obs(); n_vec++;
      if (o !== O_IDLE) begin n_err++; $display("FAIL pwr_steady: got %b want %b", o, O_IDLE); end
   endtask

   task automatic test_sub_latency();
      logic [4:0] o;
      press(B_SUB, 10);
      tick(6);
      o = obs(); n_vec++;
      if (o !== O_IDLE) begin n_err++; $display("FAIL sub_early: got %b want %b", o, O_IDLE); end
      tick(1);
      o = obs(); n_vec++;
      if (o !== O_SUB1) begin n_err++; $display("FAIL sub_first: got %b want %b", o, O_SUB1); end
      tick(1);
      o = obs(); n_vec++;
      if (o !== O_SUB) begin n_err++; $display("FAIL sub_steady: got %b want %b", o, O_SUB); end
   endtask

   task automatic test_glitch();
      logic [4:0] o;
      press(B_ADD, 2);
      for (int i = 0; i < 15; i++) begin
         tick(1);
         o = obs(); n_vec++;
         if (o !== O_SUB) begin n_err++; $display("FAIL glitch_c%0d: got %b want %b", i, o, O_SUB); end
      end
   endtask

   task automatic test_hold_no_repeat();
      logic [4:0] o;
      set_btns(B_ADD);
      tick(30);
      o = obs(); n_vec++;
      if (o !== O_SUB) begin n_err++; $display("FAIL hold_pressed: got %b want %b", o, O_SUB); end
      set_btns(4'b0000);
      tick(6);
      o = obs(); n_vec++;
      if (o !== O_SUB) begin n_err++; $display("FAIL hold_early: got %b want %b", o, O_SUB); end
      tick(1);
      o = obs(); n_vec++;
      if (o !== O_ADD1) begin n_err++; $display("FAIL hold_release: got %b want %b", o, O_ADD1); end
      for (int i = 0; i < 10; i++) begin
         tick(1);
         o = obs(); n_vec++;
         if (o !== O_ADD) begin n_err++; $display("FAIL hold_once_c%0d: got %b want %b", i, o, O_ADD); end
      end
   endtask

   task automatic test_same_op();
      logic [4:0] o;
      press(B_ADD, 10);
      for (int i = 0; i < 12; i++) begin
         tick(1);
         o = obs(); n_vec++;
         if (o !== O_ADD) begin n_err++; $display("FAIL same_op_c%0d: got %b want %b", i, o, O_ADD); end
      end
   endtask

`ifdef IR_CMD_EN
   task automatic test_ir_decode();
      logic [4:0] o;
      send_ir(32'hEF106B86);
      o = obs(); n_vec++;
      if (o !== O_MUL1) begin n_err++; $display("FAIL ir_mul: got %b want %b", o, O_MUL1); end
      send_ir(32'h12345678);
      o = obs(); n_vec++;
      if (o !== O_MUL) begin n_err++; $display("FAIL ir_junk: got %b want %b", o, O_MUL); end
      tick(3);
      o = obs(); n_vec++;
      if (o !== O_MUL) begin n_err++; $display("FAIL ir_junk_late: got %b want %b", o, O_MUL); end
   endtask

   task automatic test_ir_arb();
      logic [4:0] o;
      // IR ADD lands in the same cycle as the mul release pulse
      press(B_MUL, 10);
      tick(6);
      send_ir(32'hF00F6B86);
      o = obs(); n_vec++;
      if (o !== O_ADD1) begin n_err++; $display("FAIL ir_vs_btn: got %b want %b", o, O_ADD1); end
      // IR PWR lands with the add release pulse
      press(B_ADD, 10);
      tick(6);
      send_ir(32'hED126B86);
      o = obs(); n_vec++;
      if (o !== O_OFF1) begin n_err++; $display("FAIL ir_pwr_wins: got %b want %b", o, O_OFF1); end
      press(B_PWR, 10);
      tick(7);
      o = obs(); n_vec++;
      if (o !== O_IDLE1) begin n_err++; $display("FAIL ir_repower: got %b want %b", o, O_IDLE1); end
   endtask
`endif

   task automatic test_button_arb();
      logic [4:0] o;
      press(B_SUB | B_MUL, 10);
      tick(7);
      o = obs(); n_vec++;
      if (o !== O_SUB1) begin n_err++; $display("FAIL arb_sub_mul: got %b want %b", o, O_SUB1); end
      press(B_PWR | B_ADD, 10);
      tick(7);
      o = obs(); n_vec++;
      if (o !== O_OFF1) begin n_err++; $display("FAIL arb_pwr_add: got %b want %b", o, O_OFF1); end
      tick(1);
      o = obs(); n_vec++;
      if (o !== O_OFF) begin n_err++; $display("FAIL arb_off_steady: got %b want %b", o, O_OFF); end
   endtask

   task automatic test_off_drops_op();
      logic [4:0] o;
      press(B_ADD, 10);
      tick(12);
      o = obs(); n_vec++;
      if (o !== O_OFF) begin n_err++; $display("FAIL off_op_ignored: got %b want %b", o, O_OFF); end
      press(B_PWR, 10);
      tick(7);
      o = obs(); n_vec++;
      if (o !== O_IDLE1) begin n_err++; $display("FAIL off_op_forgotten: got %b want %b", o, O_IDLE1); end
      tick(1);
      o = obs(); n_vec++;
      if (o !== O_IDLE) begin n_err++; $display("FAIL off_idle_steady: got %b want %b", o, O_IDLE); end
   endtask

   task automatic test_reset_mid_debounce();
      logic [4:0] o;
      press(B_MUL, 10);
      tick(7);
      o = obs(); n_vec++;
      if (o !== O_MUL1) begin n_err++; $display("FAIL rst_setup_mul: got %b want %b", o, O_MUL1); end
      tick(2);
      set_btns(B_ADD);
      tick(3);
      rst_n = 1'b0;
      #1;
      o = obs(); n_vec++;
      if (o !== O_OFF) begin n_err++; $display("FAIL rst_async: got %b want %b", o, O_OFF); end
      tick(2);
      rst_n = 1'b1;
      tick(1);
      set_btns(4'b0000);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         o = obs(); n_vec++;
         if (o !== O_OFF) begin n_err++; $display("FAIL rst_no_event_c%0d: got %b want %b", i, o, O_OFF); end
      end
      press(B_PWR, 10);
      tick(7);
      o = obs(); n_vec++;
      if (o !== O_IDLE1) begin n_err++; $display("FAIL rst_repower: got %b want %b", o, O_IDLE1); end
   endtask

   initial begin
      set_btns(4'b0000);
      bus.ir_valid = 1'b0;
      bus.ir_data  = '0;
      test_reset();
      test_power_on();
      test_sub_latency();
      test_glitch();
      test_hold_no_repeat();
      test_same_op();
`ifdef IR_CMD_EN
      test_ir_decode();
      test_ir_arb();
`endif
      test_button_arb();
      test_off_drops_op();
      test_reset_mid_debounce();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
